// File: rtl/cmd_arbiter.sv
// cmd_arbiter: packet-aware round-robin merge of requester command words onto
// one output bus, with header framing checks and a per-packet word cap.
module cmd_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int MAX_PKT_WORDS = 16
) (
  input  logic                       clk,
  input  logic                       areset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [64*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       cmd_out_wr,
  output logic [63:0]                cmd_out,
  input  logic                       cmd_out_alf,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_bad_hdr,
  output logic                       err_pkt_len,
  input  logic                       err_clr
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_PKT_WORDS + 1);

  // state | meaning
  // IDLE  | arbitrating from rr_ptr; XFER | grant_id owns the bus until its end word
  typedef enum logic {IDLE, XFER} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           cmd_out_wr_q, cmd_out_wr_d;
  logic [63:0]    cmd_out_q, cmd_out_d;
  logic           err_bad_hdr_q, err_bad_hdr_d;
  logic           err_pkt_len_q, err_pkt_len_d;

  logic [IW-1:0]  winner;
  logic           win_vld;
  logic [IW-1:0]  sel;
  logic           acc;
  logic [63:0]    acc_word;
  logic [2:0]     hdr;
  logic           bad_set, len_set, end_pkt;

  function automatic logic [IW-1:0] inc_wrap(input logic [IW-1:0] v);
    return (int'(v) == NUM_REQ - 1) ? '0 : v + 1'b1;
  endfunction

  always_comb begin
    int idx;
    idx     = 0;
    winner  = rr_ptr_q;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_vld && req_valid[idx]) begin
        win_vld = 1'b1;
        winner  = IW'(idx);
      end
    end
  end

  // Ready is withheld during reset and whenever downstream is almost full.
  always_comb begin
    sel       = (state_q == XFER) ? grant_id_q : winner;
    acc       = ~areset & ~cmd_out_alf &
                ((state_q == XFER) ? req_valid[grant_id_q] : win_vld);
    req_ready = '0;
    if (acc) req_ready[sel] = 1'b1;
    acc_word  = req_data[64*int'(sel) +: 64];
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    cnt_d        = cnt_q;
    cmd_out_wr_d = 1'b0;
    cmd_out_d    = '0;
    bad_set      = 1'b0;
    len_set      = 1'b0;
    end_pkt      = 1'b0;
    hdr          = acc_word[63:61];
    if (acc) begin
      if (state_q == IDLE) begin
        if (hdr[2:1] == 2'b10) begin
          cmd_out_wr_d = 1'b1;
          cmd_out_d    = acc_word;
          if (hdr[0]) begin
            state_d    = XFER;
            grant_id_d = winner;
            cnt_d      = CW'(1);
          end else begin
            rr_ptr_d = inc_wrap(winner);
          end
        end else begin
          bad_set  = 1'b1;
          rr_ptr_d = inc_wrap(winner);
        end
      end else begin
        cmd_out_wr_d = 1'b1;
        cmd_out_d    = acc_word;
        cnt_d        = cnt_q + 1'b1;
        if (hdr[2:1] != 2'b11) begin
          bad_set = 1'b1;
          end_pkt = 1'b1;
        end else if (!hdr[0]) begin
          end_pkt = 1'b1;
        end else if (cnt_q == CW'(MAX_PKT_WORDS - 1)) begin
          // Truncated packet still gets a well-formed end word downstream.
          cmd_out_d[63:61] = 3'b110;
          len_set          = 1'b1;
          end_pkt          = 1'b1;
        end
        if (end_pkt) begin
          state_d  = IDLE;
          rr_ptr_d = inc_wrap(grant_id_q);
        end
      end
    end
    err_bad_hdr_d = bad_set | (err_bad_hdr_q & ~err_clr);
    err_pkt_len_d = len_set | (err_pkt_len_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      cnt_q         <= '0;
      cmd_out_wr_q  <= 1'b0;
      cmd_out_q     <= '0;
      err_bad_hdr_q <= 1'b0;
      err_pkt_len_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      cnt_q         <= cnt_d;
      cmd_out_wr_q  <= cmd_out_wr_d;
      cmd_out_q     <= cmd_out_d;
      err_bad_hdr_q <= err_bad_hdr_d;
      err_pkt_len_q <= err_pkt_len_d;
    end
  end

  assign cmd_out_wr  = cmd_out_wr_q;
  assign cmd_out     = cmd_out_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == XFER);
  assign err_bad_hdr = err_bad_hdr_q;
  assign err_pkt_len = err_pkt_len_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: per-requester word queues feed the DUT and a
// cycle-level arbitration model predicts ready, output word, busy and errors.
module tb_cmd_arbiter;
  localparam int NR   = 4;
  localparam int MAXW = 4;
  localparam int QD   = 512;

  logic              clk = 1'b0;
  logic              areset;
  logic [NR-1:0]     req_valid;
  logic [64*NR-1:0]  req_data;
  logic [NR-1:0]     req_ready;
  logic              cmd_out_wr;
  logic [63:0]       cmd_out;
  logic              cmd_out_alf;
  logic [1:0]        grant_id;
  logic              busy;
  logic              err_bad_hdr;
  logic              err_pkt_len;
  logic              err_clr;

  cmd_arbiter #(.NUM_REQ(NR), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .areset(areset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .cmd_out_wr(cmd_out_wr), .cmd_out(cmd_out),
    .cmd_out_alf(cmd_out_alf), .grant_id(grant_id), .busy(busy),
    .err_bad_hdr(err_bad_hdr), .err_pkt_len(err_pkt_len), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_wr  = 0;

  logic [63:0] qbuf [NR][QD];
  int          head [NR];
  int          tail [NR];
  int          vprob;
  logic        alf_r, clr_r;

  // model: owner < 0 means no packet holds the bus
  int          m_owner, m_ptr, m_cnt, m_grant;
  bit          m_wr, m_bad, m_len;
  logic [63:0] m_out;

  function automatic logic [63:0] mkw(input logic [2:0] h, input int src, input int seq);
    return {h, 29'(src), 32'(seq)};
  endfunction

  task automatic push(input int i, input logic [63:0] w);
    qbuf[i][tail[i]] = w;
    tail[i]++;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_grant = 0;
    m_wr = 0; m_bad = 0; m_len = 0; m_out = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (head[i] < tail[i]) && ($urandom_range(99) < vprob);
      req_data[64*i +: 64] = (head[i] < tail[i]) ? qbuf[i][head[i]] : {$urandom, $urandom};
    end
    cmd_out_alf = alf_r;
    err_clr     = clr_r;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    req_valid = '0; req_data = '0; cmd_out_alf = 1'b0; err_clr = 1'b0;
    alf_r = 1'b0; clr_r = 1'b0; vprob = 100;
    repeat (2) @(posedge clk);
    #1 areset = 1'b0;
    clear_model();
  endtask

  // One clock: drive from queues, check ready mid-cycle, check outputs after the edge.
  task automatic step();
    logic [NR-1:0] er;
    logic [63:0]   w;
    logic [2:0]    h;
    bit            nb, nl;
    int            sel;
    drive();
    @(negedge clk);
    sel = -1;
    if (!cmd_out_alf) begin
      if (m_owner < 0) begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (sel < 0 && req_valid[j]) sel = j;
        end
      end else if (req_valid[m_owner]) begin
        sel = m_owner;
      end
    end
    er = '0;
    if (sel >= 0) er[sel] = 1'b1;
    total++;
    if (req_ready !== er) begin
      bad++;
      $display("FAIL req_ready: got %b want %b", req_ready, er);
    end
    nb = 0; nl = 0; m_wr = 0; m_out = '0;
    if (sel >= 0) begin
      w = req_data[64*sel +: 64];
      h = w[63:61];
      if (m_owner < 0) begin
        if (h == 3'b101) begin
          m_wr = 1; m_out = w; m_owner = sel; m_grant = sel; m_cnt = 1;
        end else if (h == 3'b100) begin
          m_wr = 1; m_out = w; m_ptr = (sel + 1) % NR;
        end else begin
          nb = 1; m_ptr = (sel + 1) % NR;
        end
      end else begin
        m_wr = 1; m_out = w; m_cnt++;
        if (h == 3'b111 && m_cnt == MAXW) begin
          m_out[63:61] = 3'b110;
          nl = 1;
        end
        if (h != 3'b111 && h != 3'b110) nb = 1;
        if (h != 3'b111 || m_cnt == MAXW) begin
          m_ptr = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end
    end
    m_bad = nb | (m_bad & !err_clr);
    m_len = nl | (m_len & !err_clr);
    @(posedge clk);
    #1;
    if (sel >= 0) head[sel]++;
    if (cmd_out_wr === 1'b1) n_wr++;
    total++;
    if (cmd_out_wr !== m_wr) begin
      bad++;
      $display("FAIL cmd_out_wr: got %b want %b", cmd_out_wr, m_wr);
    end
    total++;
    if (cmd_out !== m_out) begin
      bad++;
      $display("FAIL cmd_out: got %h want %h", cmd_out, m_out);
    end
    total++;
    if (busy !== (m_owner >= 0)) begin
      bad++;
      $display("FAIL busy: got %b want %b", busy, (m_owner >= 0));
    end
    total++;
    if (grant_id !== 2'(m_grant)) begin
      bad++;
      $display("FAIL grant_id: got %0d want %0d", grant_id, m_grant);
    end
    total++;
    if (err_bad_hdr !== m_bad) begin
      bad++;
      $display("FAIL err_bad_hdr: got %b want %b", err_bad_hdr, m_bad);
    end
    total++;
    if (err_pkt_len !== m_len) begin
      bad++;
      $display("FAIL err_pkt_len: got %b want %b", err_pkt_len, m_len);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    req_valid = '1; req_data = '0; cmd_out_alf = 1'b0; err_clr = 1'b0;
    #3;
    total++;
    if ({req_ready, cmd_out_wr, busy, grant_id, err_bad_hdr, err_pkt_len} !== '0) begin
      bad++;
      $display("FAIL reset_ctrl: got rdy=%b wr=%b busy=%b gid=%0d eb=%b el=%b want all 0",
               req_ready, cmd_out_wr, busy, grant_id, err_bad_hdr, err_pkt_len);
    end
    total++;
    if (cmd_out !== 64'h0) begin
      bad++;
      $display("FAIL reset_cmd_out: got %h want 0", cmd_out);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    push(0, 64'h8000_0000_0000_0001);
    n_wr = 0;
    repeat (3) step();
    total++;
    if (n_wr !== 1) begin
      bad++;
      $display("FAIL single_wr_count: got %0d want 1", n_wr);
    end
  endtask

  task automatic test_packet();
    do_reset();
    push(0, mkw(3'b101, 0, 1));
    push(0, mkw(3'b111, 0, 2));
    push(0, mkw(3'b110, 0, 3));
    push(1, mkw(3'b100, 1, 1));
    n_wr = 0;
    repeat (6) step();
    total++;
    if (n_wr !== 4) begin
      bad++;
      $display("FAIL packet_wr_count: got %0d want 4", n_wr);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < NR; i++) push(i, mkw(3'b100, i, s));
    n_wr = 0;
    repeat (12) step();
    total++;
    if (n_wr !== 12) begin
      bad++;
      $display("FAIL rr_no_gaps: got %0d words in 12 cycles want 12", n_wr);
    end
    step();
  endtask

  task automatic test_alf();
    do_reset();
    push(0, mkw(3'b101, 0, 1));
    push(0, mkw(3'b111, 0, 2));
    push(0, mkw(3'b111, 0, 3));
    push(0, mkw(3'b110, 0, 4));
    step();
    step();
    alf_r = 1'b1;
    n_wr = 0;
    repeat (5) step();
    total++;
    if (n_wr !== 0) begin
      bad++;
      $display("FAIL alf_stall: got %0d wr pulses want 0", n_wr);
    end
    alf_r = 1'b0;
    repeat (3) step();
    total++;
    if (n_wr !== 2) begin
      bad++;
      $display("FAIL alf_resume: got %0d words want 2", n_wr);
    end
  endtask

  task automatic test_max_len();
    do_reset();
    push(2, mkw(3'b101, 2, 0));
    for (int s = 1; s <= 6; s++) push(2, mkw(3'b111, 2, s));
    n_wr = 0;
    repeat (9) step();
    total++;
    if (n_wr !== 4 || err_pkt_len !== 1'b1) begin
      bad++;
      $display("FAIL max_len: got words=%0d len=%b want words=4 len=1", n_wr, err_pkt_len);
    end
    clr_r = 1'b1;
    step();
    clr_r = 1'b0;
    total++;
    if (err_pkt_len !== 1'b0 || err_bad_hdr !== 1'b0) begin
      bad++;
      $display("FAIL err_clr: got len=%b hdr=%b want 0 0", err_pkt_len, err_bad_hdr);
    end
  endtask

  task automatic test_bad_hdr();
    do_reset();
    push(1, mkw(3'b111, 1, 9));
    n_wr = 0;
    repeat (2) step();
    total++;
    if (n_wr !== 0 || err_bad_hdr !== 1'b1) begin
      bad++;
      $display("FAIL bad_hdr_idle: got words=%0d hdr=%b want words=0 hdr=1", n_wr, err_bad_hdr);
    end
  endtask

  task automatic test_random();
    int r;
    logic [2:0] h;
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int s = 0; s < 100; s++) begin
        r = $urandom_range(9);
        if (r < 3)       h = 3'b100;
        else if (r < 5)  h = 3'b101;
        else if (r < 8)  h = 3'b111;
        else if (r == 8) h = 3'b110;
        else             h = {1'b0, 2'($urandom_range(3))};
        push(i, mkw(h, i, s));
      end
    vprob = 75;
    for (int c = 0; c < 300; c++) begin
      alf_r = ($urandom_range(99) < 15);
      clr_r = ($urandom_range(99) < 5);
      step();
    end
    alf_r = 1'b0; clr_r = 1'b0; vprob = 100;
  endtask

  task automatic test_async_reset();
    do_reset();
    push(3, mkw(3'b111, 3, 0));
    push(2, mkw(3'b101, 2, 1));
    push(2, mkw(3'b111, 2, 2));
    push(2, mkw(3'b111, 2, 3));
    push(2, mkw(3'b110, 2, 4));
    repeat (3) step();
    drive();
    #2 areset = 1'b1;
    #1;
    total++;
    if ({req_ready, cmd_out_wr, busy, grant_id, err_bad_hdr, err_pkt_len} !== '0) begin
      bad++;
      $display("FAIL async_reset_ctrl: got rdy=%b wr=%b busy=%b gid=%0d eb=%b el=%b want all 0",
               req_ready, cmd_out_wr, busy, grant_id, err_bad_hdr, err_pkt_len);
    end
    total++;
    if (cmd_out !== 64'h0) begin
      bad++;
      $display("FAIL async_reset_cmd_out: got %h want 0", cmd_out);
    end
    do_reset();
    push(1, mkw(3'b100, 1, 7));
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_packet();
    test_round_robin();
    test_alf();
    test_max_len();
    test_bad_hdr();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
